input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 16 +
 rtl/input_conditioner_debounce_bit.sv | 49 ++++
 rtl/input_conditioner.sv | 71 +++++++
 tb/tb_input_conditioner.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants for the board input conditioner: default debounce
// window, input widths and the level each input class rests at in reset.
package input_conditioner_pkg;

    // 10 ms at 50 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEFAULT_CNT_W           = 20;

    localparam int unsigned KEY_W = 3;
    localparam int unsigned SW_W  = 8;

    // Keys are active-low, so "released" is all ones; switches rest low.
    localparam logic [KEY_W-1:0] KEY_RST = 3'b111;
    localparam logic [SW_W-1:0]  SW_RST  = 8'h00;

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One input bit: two-flop synchronizer, saturating run counter and the
// accepted (stable) level. A new level is accepted only after it has been
// seen on the synchronized signal for DEBOUNCE_CYCLES consecutive samples.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 20,
    parameter logic        RST_LEVEL       = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_stable
);

    // The counter stops at this value; the next mismatching sample accepts.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;

    assign w_differs = r_sync2 ^ r_stable;
    assign o_stable  = r_stable;

    // Synchronize the raw pin, count how long it has disagreed with the
    // accepted level, and accept it once the run is long enough.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1  <= RST_LEVEL;
            r_sync2  <= RST_LEVEL;
            r_stable <= RST_LEVEL;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board input conditioner: debounces 3 active-low pushbuttons and 8 slide
// switches for the SoC PIOs, and flags accepted key presses/releases with
// registered one-cycle pulses.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [KEY_W-1:0] key_raw,
    input  logic [SW_W-1:0]  sw_raw,
    output logic [KEY_W-1:0] key_wire_export,
    output logic [SW_W-1:0]  sw_wire_export,
    output logic [KEY_W-1:0] key_press_pulse,
    output logic [KEY_W-1:0] key_release_pulse
);

    logic [KEY_W-1:0] w_key_stable;
    logic [SW_W-1:0]  w_sw_stable;
    logic [KEY_W-1:0] r_key_prev;
    logic [KEY_W-1:0] r_press;
    logic [KEY_W-1:0] r_release;

    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RST_LEVEL       (KEY_RST[gi])
        ) u_db (
            .i_clk    (clk_clk),
            .i_rst_n  (reset_reset_n),
            .i_raw    (key_raw[gi]),
            .o_stable (w_key_stable[gi])
        );
    end

    for (genvar gi = 0; gi < SW_W; gi++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RST_LEVEL       (SW_RST[gi])
        ) u_db (
            .i_clk    (clk_clk),
            .i_rst_n  (reset_reset_n),
            .i_raw    (sw_raw[gi]),
            .o_stable (w_sw_stable[gi])
        );
    end

    // Edge detect on the accepted key levels; the previous level resets to
    // "released" so leaving reset never fakes a transition.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_key_prev <= KEY_RST;
            r_press    <= '0;
            r_release  <= '0;
        end else begin
            r_key_prev <= w_key_stable;
            r_press    <= r_key_prev & ~w_key_stable;
            r_release  <= ~r_key_prev & w_key_stable;
        end
    end

    assign key_wire_export   = w_key_stable;
    assign sw_wire_export    = w_sw_stable;
    assign key_press_pulse   = r_press;
    assign key_release_pulse = r_release;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with a 4-cycle debounce window: a vector
// table, hand-written bounce sequences and a randomized run, all checked
// against a sample-history reference model.
module tb_input_conditioner;

    localparam int D = 4;
    localparam logic [10:0] RST_VEC = 11'b00000000_111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] key_raw = 3'b000;
    logic [7:0] sw_raw = 8'h00;
    logic [2:0] key_out;
    logic [7:0] sw_out;
    logic [2:0] key_prs;
    logic [2:0] key_rel;

    int n_checks = 0;
    int n_errors = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3)
    ) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .key_raw           (key_raw),
        .sw_raw            (sw_raw),
        .key_wire_export   (key_out),
        .sw_wire_export    (sw_out),
        .key_press_pulse   (key_prs),
        .key_release_pulse (key_rel)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted when the last D synchronized
    // samples all disagree with the accepted level. Synchronized sample at
    // edge j is the raw value captured at edge j-2.
    logic [10:0] m_hist [0:D];   // index 0 = raw captured at previous edge
    logic [10:0] m_stable;
    logic [2:0]  m_to0, m_to1, m_press, m_rel;

    task automatic model_edge();
        logic [10:0] all_diff;
        logic [10:0] nxt;
        if (!rst_n) begin
            for (int k = 0; k <= D; k++) m_hist[k] = RST_VEC;
            m_stable = RST_VEC;
            m_to0 = '0; m_to1 = '0; m_press = '0; m_rel = '0;
        end else begin
            all_diff = '1;
            for (int k = 1; k <= D; k++) all_diff &= (m_hist[k] ^ m_stable);
            nxt     = m_stable ^ all_diff;
            m_press = m_to0;
            m_rel   = m_to1;
            m_to0   = m_stable[2:0] & ~nxt[2:0];
            m_to1   = ~m_stable[2:0] & nxt[2:0];
            for (int k = D; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = {sw_raw, key_raw};
            m_stable  = nxt;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge: update model, then sample the DUT 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_key",  {29'd0, key_out}, {29'd0, m_stable[2:0]});
        check("model_sw",   {24'd0, sw_out},  {24'd0, m_stable[10:3]});
        check("model_prs",  {29'd0, key_prs}, {29'd0, m_press});
        check("model_rel",  {29'd0, key_rel}, {29'd0, m_rel});
        check("prs_rel_excl", {29'd0, key_prs & key_rel}, 32'd0);
    endtask

    typedef struct {
        logic       rst_n;
        logic [2:0] key;
        logic [7:0] sw;
        int         n;
        logic [2:0] exp_key;
        logic [7:0] exp_sw;
        logic [2:0] exp_prs;
        logic [2:0] exp_rel;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int prs_cnt;
        int rel_cnt;
        logic [2:0] glitch;

        // reset hold with keys pressed, then acceptance at edge 6
        vecs.push_back(vec_t'{1'b0, 3'b000, 8'h00, 3, 3'b111, 8'h00, 3'b000, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b000, 8'h00, 5, 3'b111, 8'h00, 3'b000, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b000, 8'h00, 1, 3'b000, 8'h00, 3'b000, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b000, 8'h00, 1, 3'b000, 8'h00, 3'b111, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b000, 8'h00, 1, 3'b000, 8'h00, 3'b000, 3'b000});
        // release all
        vecs.push_back(vec_t'{1'b1, 3'b111, 8'h00, 6, 3'b111, 8'h00, 3'b000, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b111, 8'h00, 1, 3'b111, 8'h00, 3'b000, 3'b111});
        vecs.push_back(vec_t'{1'b1, 3'b111, 8'h00, 1, 3'b111, 8'h00, 3'b000, 3'b000});
        // clean press on key 1
        vecs.push_back(vec_t'{1'b1, 3'b101, 8'h00, 5, 3'b111, 8'h00, 3'b000, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b101, 8'h00, 1, 3'b101, 8'h00, 3'b000, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b101, 8'h00, 1, 3'b101, 8'h00, 3'b010, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b101, 8'h00, 1, 3'b101, 8'h00, 3'b000, 3'b000});
        // release key 1, then simultaneous switch/key change
        vecs.push_back(vec_t'{1'b1, 3'b111, 8'h00, 8, 3'b111, 8'h00, 3'b000, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b010, 8'hA5, 6, 3'b010, 8'hA5, 3'b000, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b010, 8'hA5, 1, 3'b010, 8'hA5, 3'b101, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b010, 8'hA5, 1, 3'b010, 8'hA5, 3'b000, 3'b000});
        // reset mid-count, then a fresh full window
        vecs.push_back(vec_t'{1'b1, 3'b111, 8'h00, 4, 3'b010, 8'hA5, 3'b000, 3'b000});
        vecs.push_back(vec_t'{1'b0, 3'b000, 8'hFF, 1, 3'b111, 8'h00, 3'b000, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b000, 8'hFF, 5, 3'b111, 8'h00, 3'b000, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b000, 8'hFF, 1, 3'b000, 8'hFF, 3'b000, 3'b000});
        vecs.push_back(vec_t'{1'b1, 3'b000, 8'hFF, 1, 3'b000, 8'hFF, 3'b111, 3'b000});

        for (int v = 0; v < vecs.size(); v++) begin
            rst_n   = vecs[v].rst_n;
            key_raw = vecs[v].key;
            sw_raw  = vecs[v].sw;
            for (int c = 0; c < vecs[v].n; c++) step();
            check($sformatf("vec%0d_key", v), {29'd0, key_out}, {29'd0, vecs[v].exp_key});
            check($sformatf("vec%0d_sw", v),  {24'd0, sw_out},  {24'd0, vecs[v].exp_sw});
            check($sformatf("vec%0d_prs", v), {29'd0, key_prs}, {29'd0, vecs[v].exp_prs});
            check($sformatf("vec%0d_rel", v), {29'd0, key_rel}, {29'd0, vecs[v].exp_rel});
            $display("vec %0d: key=%b sw=%h prs=%b rel=%b", v, key_out, sw_out, key_prs, key_rel);
        end

        // switch 5 bounce: 3 high / 2 low, five times, never accepted
        key_raw = 3'b111;
        sw_raw  = 8'h00;
        for (int c = 0; c < 10; c++) step();
        for (int r = 0; r < 5; r++) begin
            sw_raw = 8'h20;
            for (int c = 0; c < 3; c++) begin step(); check("bounce_sw", {24'd0, sw_out}, 32'd0); end
            sw_raw = 8'h00;
            for (int c = 0; c < 2; c++) begin step(); check("bounce_sw", {24'd0, sw_out}, 32'd0); end
        end
        // counter must be back at 0: steady high needs the full D+2 edges
        sw_raw = 8'h20;
        for (int c = 0; c < 5; c++) step();
        check("bounce_settle_early", {24'd0, sw_out}, 32'd0);
        step();
        check("bounce_settle", {24'd0, sw_out}, 32'h20);
        $display("bounce reject: sw=%h", sw_out);

        // key 0 press with glitches, then release with glitches
        prs_cnt = 0;
        glitch  = 3'b000;
        foreach (glitch[i]) glitch[i] = 1'b0;
        for (int c = 0; c < 17; c++) begin
            key_raw = (c < 7) ? {2'b11, 1'((7'b1010010 >> c) & 7'd1)} : 3'b110;
            step();
            prs_cnt += int'(key_prs[0]);
        end
        check("glitch_press_count", prs_cnt, 1);
        rel_cnt = 0;
        for (int c = 0; c < 17; c++) begin
            key_raw = (c < 7) ? {2'b11, 1'((7'b0101101 >> c) & 7'd1)} : 3'b111;
            step();
            rel_cnt += int'(key_rel[0]);
        end
        check("glitch_release_count", rel_cnt, 1);
        $display("glitch seq: presses=%0d releases=%0d", prs_cnt, rel_cnt);

        // randomized run with occasional reset
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) key_raw[b] = ~key_raw[b];
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) sw_raw[b] = ~sw_raw[b];
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1;
        $display("random run done: key=%b sw=%h", key_out, sw_out);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
